uart_rx_fifo: RTL

//  Receive-side byte buffer between the uart receiver and the core data bus. Captures every

---
 rtl/uart_rx_fifo.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//  Receive-side byte buffer between the uart receiver and the core data bus.
//  Every received byte is captured into a 2**DEPTH_LOG2 entry FIFO. Software
//  drains it through a small register window, and a level interrupt is raised
//  when the fill level reaches a threshold or a byte was lost.
//
//  Register window (word offset = addr_i[3:2]):
//   0x0 DATA   R : head byte (0 when empty); a read access pops one entry
//   0x4 STATUS R : {count, timeout, overrun, full, empty}; W: bit2/bit3 clear
//   0x8 CTRL   RW: bit0 irq_en, [15:8] thresh, [23:16] tmo, bit31 flush
//
//  Optional feature macro: UART_RX_TIMEOUT_IRQ_EN
//   When defined, an idle counter raises a sticky timeout flag once the FIFO
//   has held data for tmo*1024 clocks with no push or pop. When undefined,
//   the tmo field and the timeout flag read as 0 and no counter is built.
//
//  Ports:
//   clk_i       system clock
//   reset       asynchronous active-low reset
//   rx_valid_i  one-cycle strobe, rx_byte_i holds a new byte
//   rx_byte_i   received byte
//   csb_i       chip select, active-low
//   wen_i       0 = write, 1 = read
//   addr_i      byte offset within the block
//   data_i      write data
//   wmask_i     byte write enables for data_i
//   data_o      read data, combinational from addr_i and state
//   irq_o       registered level interrupt
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic        clk_i,
   input  logic        reset,
   input  logic        rx_valid_i,
   input  logic [7:0]  rx_byte_i,
   input  logic        csb_i,
   input  logic        wen_i,
   input  logic [3:0]  addr_i,
   input  logic [31:0] data_i,
   input  logic [3:0]  wmask_i,
   output logic [31:0] data_o,
   output logic        irq_o
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
   localparam logic [DEPTH_LOG2:0]   CNT_ONE = 1;
   localparam logic [DEPTH_LOG2:0]   CNT_FULL = DEPTH;

   logic [7:0]            r_mem [DEPTH];
   logic [DEPTH_LOG2-1:0] r_wr_ptr;
   logic [DEPTH_LOG2-1:0] r_rd_ptr;
   logic [DEPTH_LOG2:0]   r_count;
   logic                  r_overrun;
   logic                  r_irq_en;
   logic [7:0]            r_thresh;
   logic                  r_acc_q;
   logic                  r_irq;

   logic                  w_access;
   logic                  w_fire;
   logic                  w_empty;
   logic                  w_full;
   logic                  w_pop;
   logic                  w_push;
   logic                  w_wr_stat;
   logic                  w_wr_ctrl;
   logic                  w_flush;
   logic                  w_clr_ovr;
   logic                  w_overrun_next;
   logic [DEPTH_LOG2:0]   w_count_next;
   logic [7:0]            w_thresh_eff;
   logic [15:0]           w_count16;
   logic [7:0]            w_tmo_rd;
   logic                  w_timeout_bit;
   logic                  w_timeout_next;
   logic                  w_unused;

   assign w_access  = !csb_i;
   // Only the first cycle of an access acts, so a stalled bus pops once.
   assign w_fire    = w_access & !r_acc_q;
   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == CNT_FULL);
   assign w_pop     = w_fire & wen_i & (addr_i[3:2] == 2'd0) & !w_empty;
   assign w_wr_stat = w_fire & !wen_i & (addr_i[3:2] == 2'd1);
   assign w_wr_ctrl = w_fire & !wen_i & (addr_i[3:2] == 2'd2);
   assign w_flush   = w_wr_ctrl & wmask_i[3] & data_i[31];
   assign w_clr_ovr = w_wr_stat & wmask_i[0] & data_i[2];
   // A pop on a full FIFO frees the slot the same edge, so the push is taken.
   assign w_push    = rx_valid_i & (!w_full | w_pop) & !w_flush;

   always_comb begin
      w_overrun_next = r_overrun;
      if (w_flush)
         w_overrun_next = 1'b0;
      else if (rx_valid_i && w_full && !w_pop)
         w_overrun_next = 1'b1;
      else if (w_clr_ovr)
         w_overrun_next = 1'b0;
   end

   always_comb begin
      w_count_next = r_count;
      if (w_flush)
         w_count_next = '0;
      else if (w_push && !w_pop)
         w_count_next = r_count + CNT_ONE;
      else if (w_pop && !w_push)
         w_count_next = r_count - CNT_ONE;
   end

   assign w_thresh_eff = (r_thresh == 8'd0) ? 8'd1 : r_thresh;
   assign w_count16    = 16'(r_count);

`ifdef UART_RX_TIMEOUT_IRQ_EN
   logic [7:0]  r_tmo;
   logic [17:0] r_idle;
   logic        r_timeout;
   logic        w_timeout_hit;
   logic        w_clr_tmo;

   assign w_timeout_hit  = (r_tmo != 8'd0) && !w_empty && (r_idle == {r_tmo, 10'b0});
   assign w_clr_tmo      = w_wr_stat & wmask_i[0] & data_i[3];
   assign w_timeout_next = w_timeout_hit | (r_timeout & !w_clr_tmo);
   assign w_tmo_rd       = r_tmo;
   assign w_timeout_bit  = r_timeout;

   always_ff @(posedge clk_i or negedge reset) begin
      if (!reset) begin
         r_tmo     <= '0;
         r_idle    <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= w_timeout_next;
         if (w_wr_ctrl && wmask_i[2])
            r_tmo <= data_i[23:16];
         // Saturating idle counter, restarted by any FIFO activity.
         if (w_push || w_pop || w_flush || w_empty)
            r_idle <= '0;
         else if (r_idle != 18'h3FFFF)
            r_idle <= r_idle + 18'd1;
      end
   end
`else
   assign w_tmo_rd       = 8'd0;
   assign w_timeout_bit  = 1'b0;
   assign w_timeout_next = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (w_push)
         r_mem[r_wr_ptr] <= rx_byte_i;
   end

   always_ff @(posedge clk_i or negedge reset) begin
      if (!reset) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_overrun <= 1'b0;
         r_irq_en  <= 1'b0;
         r_thresh  <= 8'd1;
         r_acc_q   <= 1'b0;
         r_irq     <= 1'b0;
      end else begin
         r_acc_q   <= w_access;
         r_count   <= w_count_next;
         r_overrun <= w_overrun_next;
         r_irq     <= r_irq_en & ((16'(w_count_next) >= 16'(w_thresh_eff))
                                  | w_overrun_next | w_timeout_next);
         if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
         end else begin
            if (w_push)
               r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)
               r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
         if (w_wr_ctrl && wmask_i[0])
            r_irq_en <= data_i[0];
         if (w_wr_ctrl && wmask_i[1])
            r_thresh <= data_i[15:8];
      end
   end

   always_comb begin
      data_o = '0;
      case (addr_i[3:2])
         2'd0: if (!w_empty) data_o = {24'b0, r_mem[r_rd_ptr]};
         2'd1: data_o = {16'b0, w_count16[7:0], 4'b0, w_timeout_bit,
                         r_overrun, w_full, w_empty};
         2'd2: data_o = {8'b0, w_tmo_rd, r_thresh, 7'b0, r_irq_en};
         default: data_o = '0;
      endcase
   end

   assign irq_o = r_irq;

   // Bits of the bus that no register decodes.
   assign w_unused = ^{addr_i[1:0], data_i, wmask_i};
endmodule
